// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one fifo_buffer write port
// between NUM_REQ producers, with a one-entry output register.
// Optional feature: define ARB_BURST_LOCK_EN to keep the grant on one producer
// until it presents a word flagged with req_last.
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PAR_WRITE  = 1,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ*DATA_WIDTH*PAR_WRITE-1:0]  req_data,
    input  logic [NUM_REQ-1:0]                       req_last,
    output logic [NUM_REQ-1:0]                       grant,
    output logic                                     fifo_w_en,
    output logic [DATA_WIDTH*PAR_WRITE-1:0]          fifo_data,
    input  logic                                     fifo_ready
);

    localparam int unsigned W = DATA_WIDTH * PAR_WRITE;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_WIDTH-1:0]   rr_ptr;
    logic [NUM_REQ-1:0]     eligible;
    logic                   accept;
    logic                   found;
    logic                   grant_en;
    logic [PTR_WIDTH-1:0]   winner;
    logic [PTR_WIDTH-1:0]   next_ptr;
    logic [W-1:0]           sel_data;
    int unsigned            idx;

`ifdef ARB_BURST_LOCK_EN
    logic                   lock_active;
    logic [PTR_WIDTH-1:0]   lock_owner;

    // While a burst is open only its owner may compete.
    always_comb begin
        eligible = req;
        if (lock_active) begin
            eligible = req & (NUM_REQ'(1) << lock_owner);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;

    // Every word is arbitrated on its own.
    always_comb begin
        eligible = req;
    end
`endif

    // Winner search from rr_ptr upward with wrap; grant is gated by reset
    // so it reads zero while rst_n is low.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = PTR_WIDTH'(idx);
            end
        end
        accept   = (state == ST_EMPTY) || fifo_ready;
        grant_en = rst_n && accept && found;
        grant    = grant_en ? (NUM_REQ'(1) << winner) : '0;
        next_ptr = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_WIDTH'(1);
        sel_data = req_data[32'(winner) * W +: W];
    end

    // Output register, state and round-robin pointer; a grant may load a new
    // word on the same edge the old one drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            fifo_w_en   <= 1'b0;
            fifo_data   <= '0;
            rr_ptr      <= '0;
`ifdef ARB_BURST_LOCK_EN
            lock_active <= 1'b0;
            lock_owner  <= '0;
`endif
        end else if (grant_en) begin
            state     <= ST_LOADED;
            fifo_w_en <= 1'b1;
            fifo_data <= sel_data;
`ifdef ARB_BURST_LOCK_EN
            if (req_last[winner]) begin
                lock_active <= 1'b0;
                rr_ptr      <= next_ptr;
            end else begin
                lock_active <= 1'b1;
                lock_owner  <= winner;
            end
`else
            rr_ptr    <= next_ptr;
`endif
        end else if ((state == ST_LOADED) && fifo_ready) begin
            state     <= ST_EMPTY;
            fifo_w_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter against a queue-based model.
module tb_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   grant;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_data;
    logic           fifo_ready;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] dut_wr[$];
    logic [W-1:0] m_wr[$];
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ptr;
    bit           m_lock;
    int           m_owner;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_WIDTH(16),
        .PAR_WRITE (1),
        .NUM_REQ   (N),
        .PTR_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .grant     (grant),
        .fifo_w_en (fifo_w_en),
        .fifo_data (fifo_data),
        .fifo_ready(fifo_ready)
    );

    // Record every word actually handed to the buffer.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && fifo_w_en === 1'b1 && fifo_ready === 1'b1)
            dut_wr.push_back(fifo_data);
    end

    // ---------------- reference model ----------------
    task automatic m_reset();
        m_valid = 0; m_data = '0; m_ptr = 0; m_lock = 0; m_owner = 0;
    endtask

    // Requester closest to the pointer (cyclic distance) wins.
    function automatic int m_winner();
        int best, bestd, d;
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i] === 1'b1 && !(m_lock && i != m_owner)) begin
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        int w;
        g = '0;
        w = m_winner();
        if (rst_n === 1'b1 && (!m_valid || fifo_ready === 1'b1) && w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic m_edge(output int gw);
        int w;
        bit acc;
        w   = m_winner();
        acc = !m_valid || (fifo_ready === 1'b1);
        gw  = -1;
        if (m_valid && fifo_ready === 1'b1) m_wr.push_back(m_data);
        if (acc && w >= 0) begin
            gw      = w;
            m_valid = 1;
            m_data  = req_data[w*W +: W];
`ifdef ARB_BURST_LOCK_EN
            if (req_last[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
            else begin m_lock = 1; m_owner = w; end
`else
            m_ptr = (w + 1) % N;
`endif
        end else if (acc) begin
            m_valid = 0;
        end
    endtask

    // Model-tracked cycle without comparisons (used for draining).
    task automatic quiet_cycle();
        int gw;
        @(negedge clk);
        m_edge(gw);
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int gw;
        logic [N-1:0] eg;
        rst_n = 1'b0; req = '0; req_last = '1; req_data = '0; fifo_ready = 1'b0;
        m_reset();
        #2;
        checks++;
        if (fifo_w_en !== 1'b0 || fifo_data !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_init: w_en=%b data=%h grant=%b want 0/0/0", fifo_w_en, fifo_data, grant);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        req = 4'b0001; req_data[0 +: W] = 16'h1234;
        @(negedge clk);
        eg = m_grant();
        checks++;
        if (grant !== eg) begin
            errors++; $display("FAIL reset_load_grant: got %b want %b", grant, eg);
        end
        m_edge(gw);
        @(posedge clk); #1;
        checks++;
        if (fifo_w_en !== 1'b1 || fifo_data !== 16'h1234) begin
            errors++; $display("FAIL reset_loaded: w_en=%b data=%h want 1/1234", fifo_w_en, fifo_data);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_w_en !== 1'b0 || fifo_data !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_async: w_en=%b data=%h grant=%b want 0/0/0", fifo_w_en, fifo_data, grant);
        end
        m_reset();
        req = '0; fifo_ready = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== '0) begin errors++; $display("FAIL reset_idle_grant: got %b want 0", grant); end
            m_edge(gw);
            @(posedge clk); #1;
            checks++;
            if (fifo_w_en !== 1'b0) begin errors++; $display("FAIL reset_idle_wen: got %b want 0", fifo_w_en); end
        end
        checks++;
        if (dut_wr.size() != 0) begin
            errors++; $display("FAIL reset_discard: writes=%0d want 0", dut_wr.size());
        end
    endtask

    task automatic test_round_robin();
        int gw;
        logic [N-1:0] eg, cg;
        dut_wr.delete(); m_wr.delete();
        fifo_ready = 1'b1; req = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(32'hA000 + i);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            eg = m_grant();
            cg = '0; cg[c % N] = 1'b1;
            checks++;
            if (grant !== eg || grant !== cg) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, grant, cg);
            end
            m_edge(gw);
            @(posedge clk); #1;
            checks++;
            if (fifo_w_en !== 1'b1 || fifo_data !== m_data) begin
                errors++; $display("FAIL rr_data[%0d]: got %b/%h want 1/%h", c, fifo_w_en, fifo_data, m_data);
            end
        end
        req = '0;
        quiet_cycle();
        checks++;
        if (dut_wr.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d want 8", dut_wr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dut_wr[i] !== m_wr[i] || dut_wr[i] !== W'(32'hA000 + i % N)) begin
                    errors++; $display("FAIL rr_write[%0d]: got %h want %h", i, dut_wr[i], W'(32'hA000 + i % N));
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int gw;
        logic [N-1:0] eg;
        dut_wr.delete(); m_wr.delete();
        fifo_ready = 1'b0; req = 4'b0101; req_last = 4'b1111;
        req_data[0 +: W] = 16'hC000; req_data[2*W +: W] = 16'hC002;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) req = 4'b0100;
            if (c == 6) fifo_ready = 1'b1;
            @(negedge clk);
            eg = m_grant();
            checks++;
            if (grant !== eg || (c == 0 && grant !== 4'b0001) || (c > 0 && c < 6 && grant !== 4'b0000)
                || (c == 6 && grant !== 4'b0100)) begin
                errors++; $display("FAIL bp_grant[%0d]: got %b want %b", c, grant, eg);
            end
            m_edge(gw);
            @(posedge clk); #1;
            checks++;
            if (fifo_w_en !== 1'b1 || fifo_data !== m_data) begin
                errors++; $display("FAIL bp_data[%0d]: got %b/%h want 1/%h", c, fifo_w_en, fifo_data, m_data);
            end
        end
        req = '0;
        quiet_cycle();
        checks++;
        if (dut_wr.size() != 2 || dut_wr[0] !== 16'hC000 || dut_wr[1] !== 16'hC002) begin
            errors++; $display("FAIL bp_writes: got %0d writes want C000,C002", dut_wr.size());
        end
    endtask

    task automatic test_wrap();
        int gw;
        logic [N-1:0] eg;
        logic [N-1:0] reqs [6] = '{4'b0100, 4'b0010, 4'b1001, 4'b0000, 4'b0000, 4'b0011};
        logic [N-1:0] exps [6] = '{4'b0100, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
        fifo_ready = 1'b1; req_last = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            req = reqs[c];
            req_data = {$urandom, $urandom};
            @(negedge clk);
            eg = m_grant();
            checks++;
            if (grant !== eg || grant !== exps[c]) begin
                errors++; $display("FAIL wrap_grant[%0d]: got %b want %b", c, grant, exps[c]);
            end
            m_edge(gw);
            @(posedge clk); #1;
        end
        req = '0;
        quiet_cycle();
    endtask

    task automatic test_burst();
        int gw, widx, cnt0, cyc;
        int ord[$];
        int exp_ord[4];
        logic [N-1:0] eg;
`ifdef ARB_BURST_LOCK_EN
        exp_ord = '{1, 1, 1, 0};
`else
        exp_ord = '{1, 0, 1, 0};
`endif
        fifo_ready = 1'b1; req_last = 4'b1111;
        req = 4'b0001; req_data[0 +: W] = 16'hD0FF;
        quiet_cycle();
        widx = 0; cnt0 = 0; cyc = 0;
        while (ord.size() < 4 && cyc < 20) begin
            req      = {2'b00, (widx < 3), 1'b1};
            req_last = {2'b11, (widx == 2), 1'b1};
            req_data[0 +: W] = W'(32'hD000 + cnt0);
            req_data[W +: W] = W'(32'hB000 + widx);
            @(negedge clk);
            eg = m_grant();
            checks++;
            if (grant !== eg) begin
                errors++; $display("FAIL burst_grant[%0d]: got %b want %b", cyc, grant, eg);
            end
            m_edge(gw);
            if (gw >= 0) ord.push_back(gw);
            if (gw == 1) widx++;
            if (gw == 0) cnt0++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (ord.size() < 4) begin
            errors++; $display("FAIL burst_timeout: got %0d grants want 4", ord.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ord[i] != exp_ord[i]) begin
                    errors++; $display("FAIL burst_order[%0d]: got %0d want %0d", i, ord[i], exp_ord[i]);
                end
            end
        end
        req = '0;
        quiet_cycle();
    endtask

    task automatic test_random();
        int gw;
        logic [N-1:0] eg;
        logic [N-1:0] pend;
        dut_wr.delete(); m_wr.delete();
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    req_data[i*W +: W] = W'($urandom);
                    req_last[i] = ($urandom % 3 != 0);
                end
            end
            req = pend;
            fifo_ready = ($urandom % 4 != 0);
            @(negedge clk);
            eg = m_grant();
            checks++;
            if (grant !== eg) begin
                errors++; $display("FAIL rand_grant[%0d]: got %b want %b", c, grant, eg);
            end
            m_edge(gw);
            if (gw >= 0) pend[gw] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (fifo_w_en !== m_valid || (m_valid && fifo_data !== m_data)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got %b/%h want %b/%h", c, fifo_w_en, fifo_data, m_valid, m_data);
            end
        end
        req = '0; fifo_ready = 1'b1;
        quiet_cycle();
        quiet_cycle();
        checks++;
        if (dut_wr.size() != m_wr.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", dut_wr.size(), m_wr.size());
        end else begin
            for (int i = 0; i < m_wr.size(); i++) begin
                checks++;
                if (dut_wr[i] !== m_wr[i]) begin
                    errors++; $display("FAIL rand_write[%0d]: got %h want %h", i, dut_wr[i], m_wr[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_wrap();
        test_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of one `fifo_buffer` instance between `NUM_REQ` producers. It sits directly in front of the buffer's `w_en`/`data_in`/`ready` write handshake. A one-entry output register decouples producer grants from buffer back-pressure, so full throughput is one word per cycle while the buffer is ready.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per element; must match the buffer.
- `PAR_WRITE`, 1: elements per write word; word width W = DATA_WIDTH*PAR_WRITE.
- `NUM_REQ`, 4: number of producers, 2..8.
- `PTR_WIDTH`, 2: width of the round-robin pointer; must satisfy 2^PTR_WIDTH >= NUM_REQ.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: bit i high means producer i has a valid word on its data slice.
- `req_data` input NUM_REQ*W: producer i's word is bits [i*W +: W].
- `req_last` input NUM_REQ: bit i marks producer i's current word as the end of a burst. Used only with `ARB_BURST_LOCK_EN`; otherwise ignored.
- `grant` output NUM_REQ: one-hot or zero, combinational. Bit i high means producer i's word is captured at this rising edge.
- `fifo_w_en` output 1: the output register holds a word. Connects to the buffer's `w_en`.
- `fifo_data` output W: the output register word. Connects to the buffer's `data_in`.
- `fifo_ready` input 1: the buffer's `ready`; the word transfers when `fifo_w_en && fifo_ready`.

## Operation
- The state machine has two states:
  - EMPTY: output register invalid.
  - LOADED: output register valid.
- `accept` = (state==EMPTY) || fifo_ready.
- **Winner selection:** the first index with `req` high, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
- `grant[winner]` = accept && |req. All other grant bits are 0.
- **On a grant edge:**
  - The winner's `req_data` is loaded into `fifo_data`.
  - The state becomes LOADED.
  - `rr_ptr` becomes (winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- **On an edge with state LOADED, fifo_ready high and no grant:** the state becomes EMPTY.
- **On an edge with state LOADED and fifo_ready low:** state and data are held, and `grant` is 0 in that cycle.
- **Simultaneous drain and grant (LOADED, fifo_ready high, |req high):** the old word transfers to the buffer and the new word is loaded in the same edge. There is no bubble.
- **Producer contract:**
  - `req` and the producer's data are held stable until granted.
  - After a grant, the producer presents its next word or drops `req` at the following cycle.
- **No requests:** no grant, and `rr_ptr` is unchanged.

## Timing
- **Reset values** (immediate on `rst_n` low, independent of `clk`):
  - state EMPTY
  - `fifo_w_en` 0
  - `fifo_data` 0
  - `rr_ptr` 0
  - lock cleared
  - `grant` 0
- **Reset mid-operation:** a word held in the output register is discarded. It is never written to the buffer.
- **Latency:** a grant at edge N makes `fifo_w_en` high in cycle N+1 (one cycle).
- **Throughput:** with `fifo_ready` held high and requests pending, one grant and one buffer write per cycle.
- **Fairness:** with every requester continuously active, each is granted exactly once per NUM_REQ consecutive grants.
- **Combinational paths:** `grant` depends combinationally on `req`, `fifo_ready`, the state and the lock. No other output is combinational.

## Configuration
- `ARB_BURST_LOCK_EN` defined:
  - A grant to producer i with `req_last[i]`=0 sets lock owner = i.
  - While the lock is set, only producer i can win. Other requests wait even if producer i drops `req`.
  - The lock clears on the edge that grants producer i with `req_last[i]`=1.
  - `rr_ptr` advances only when the lock clears.
- `ARB_BURST_LOCK_EN` undefined:
  - The lock logic and `req_last` usage are absent.
  - Every word is arbitrated independently.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle while LOADED.
  - `fifo_w_en`, `fifo_data` and `grant` are 0 immediately.
  - After release with no requests, nothing is written.
- **Round-robin:** req=4'b1111 with fifo_ready=1 for 8 cycles.
  - Grant order is 0,1,2,3,0,1,2,3.
  - 8 buffer writes carry data 0xA000+i in the same order.
- **Back-pressure:** req=4'b0101 with fifo_ready=0 for 5 cycles.
  - One grant (producer 0), then `grant`=0 and `fifo_data` stable for 5 cycles.
  - When fifo_ready rises, producer 2 is granted in the same cycle as the drain.
- **Pointer wrap and skip:** rr_ptr=3, req=4'b0010.
  - Producer 1 wins and rr_ptr becomes 2.
  - Next, req=4'b1001 gives producer 3 the grant, then rr_ptr becomes 0.
- **Burst lock (`ARB_BURST_LOCK_EN`):** producer 1 sends 3 words with req_last on word 3 while producer 0 requests continuously.
  - Grants are 1,1,1,0.
  - Without the macro, grants are 1,0,1,0 interleaved under the same stimulus.
